// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t      : FSM state encoding (IDLE, CALC, DONE)
//   DIV_SIZE_DEFAULT : default operand width
//   cnt_width()      : width of the step counter, wide enough to hold SIZE
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_SIZE_DEFAULT = 8;

    // Counter must represent the value SIZE itself, hence SIZE+1 codes.
    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Handshake/data bundle between the ALU control FSM and the divider.
//   start, a, b                                 : request side (driven by master)
//   quotient, remainder, div_by_zero, busy, done: response side (driven by slave)
interface sequential_divider_if
    import divider_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEFAULT
);
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            div_by_zero;
    logic            busy;
    logic            done;

    modport master (
        output start, a, b,
        input  quotient, remainder, div_by_zero, busy, done
    );

    modport slave (
        input  start, a, b,
        output quotient, remainder, div_by_zero, busy, done
    );
endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division step.
//   rem_in       : current partial remainder (always < divisor, so SIZE bits suffice)
//   dividend_msb : next dividend bit shifted into the remainder
//   divisor      : divisor
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this step
module divider_step
    import divider_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEFAULT
) (
    input  logic [SIZE-1:0] rem_in,
    input  logic            dividend_msb,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE-1:0] rem_out,
    output logic            q_bit
);
    // Trial remainder is one bit wider so the compare/subtract cannot overflow.
    logic [SIZE:0] trial_s;

    // Shift in the dividend bit, then subtract the divisor if it fits.
    always_comb begin
        trial_s = {rem_in, dividend_msb};
        if (trial_s >= {1'b0, divisor}) begin
            // Result is below the divisor, so dropping the top bit is exact.
            rem_out = SIZE'(trial_s - {1'b0, divisor});
            q_bit   = 1'b1;
        end else begin
            rem_out = trial_s[SIZE-1:0];
            q_bit   = 1'b0;
        end
    end
endmodule

// File: rtl/sequential_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sequential_divider_if
//           start/a/b in; quotient/remainder/div_by_zero/busy/done out (all registered)
// A start in IDLE captures the operands; SIZE CALC steps later the results are
// loaded and done pulses for one cycle in DONE, then the FSM returns to IDLE.
module sequential_divider
    import divider_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sequential_divider_if.slave  bus
);
    localparam int CW = cnt_width(SIZE);

    div_state_t      state_r;
    div_state_t      next_state_s;
    // Holds the dividend; quotient bits are shifted in at the bottom as the
    // dividend bits leave at the top, so after SIZE steps it holds the quotient.
    logic [SIZE-1:0] work_r;
    logic [SIZE-1:0] divisor_r;
    logic [SIZE-1:0] rem_r;
    logic [CW-1:0]   count_r;
    logic            dbz_pend_r;
    logic [SIZE-1:0] quotient_r;
    logic [SIZE-1:0] remainder_r;
    logic            dbz_r;
    logic            busy_r;
    logic            done_r;
    logic [SIZE-1:0] rem_next_s;
    logic            q_bit_s;
    logic            last_step_s;

    divider_step #(.SIZE(SIZE)) u_step (
        .rem_in       (rem_r),
        .dividend_msb (work_r[SIZE-1]),
        .divisor      (divisor_r),
        .rem_out      (rem_next_s),
        .q_bit        (q_bit_s)
    );

    assign last_step_s = (state_r == CALC) && (count_r == CW'(1));

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (last_step_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CALC;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r      <= {SIZE{1'b0}};
            divisor_r   <= {SIZE{1'b0}};
            rem_r       <= {SIZE{1'b0}};
            count_r     <= {CW{1'b0}};
            dbz_pend_r  <= 1'b0;
            quotient_r  <= {SIZE{1'b0}};
            remainder_r <= {SIZE{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        work_r     <= bus.a;
                        divisor_r  <= bus.b;
                        rem_r      <= {SIZE{1'b0}};
                        count_r    <= CW'(SIZE);
                        dbz_pend_r <= (bus.b == {SIZE{1'b0}});
                    end
                end
                CALC: begin
                    work_r  <= {work_r[SIZE-2:0], q_bit_s};
                    rem_r   <= rem_next_s;
                    count_r <= count_r - CW'(1);
                    if (last_step_s) begin
                        quotient_r  <= {work_r[SIZE-2:0], q_bit_s};
                        remainder_r <= rem_next_s;
                        dbz_r       <= dbz_pend_r;
                    end
                end
                DONE: begin
                    count_r <= {CW{1'b0}};
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == CALC);
            done_r <= (next_state_s == DONE);
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
endmodule

// File: tb/tb_sequential_divider.sv
module tb_sequential_divider;
    import divider_pkg::*;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   done8_cnt;
    exp_t q8[$];
    exp_t q2[$];
    exp_t last8;

    sequential_divider_if #(.SIZE(8)) i8 ();
    sequential_divider_if #(.SIZE(2)) i2 ();

    sequential_divider #(.SIZE(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    sequential_divider #(.SIZE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: plain arithmetic, b==0 gives all-ones quotient and a.
    function automatic exp_t model(input int unsigned aa, input int unsigned bb, input int w);
        exp_t e;
        int unsigned ones;
        ones = (32'd1 << w) - 32'd1;
        if (bb == 0) begin
            e.q = 8'(ones); e.r = 8'(aa); e.dbz = 1'b1;
        end else begin
            e.q = 8'(aa / bb); e.r = 8'(aa % bb); e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor / scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_done_excl8", {31'd0, i8.busy & i8.done}, 32'd0);
            if (i8.done) begin
                exp_t e;
                done8_cnt++;
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb8_unexpected_done: got done with empty queue, expected none");
                end else begin
                    e = q8.pop_front();
                    chk("quotient8", {24'd0, i8.quotient}, {24'd0, e.q});
                    chk("remainder8", {24'd0, i8.remainder}, {24'd0, e.r});
                    chk("dbz8", {31'd0, i8.div_by_zero}, {31'd0, e.dbz});
                end
            end
        end
    end

    // Monitor / scoreboard for the 2-bit instance.
    always @(negedge clk) begin
        if (rst_n && i2.done) begin
            exp_t e;
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL sb2_unexpected_done: got done with empty queue, expected none");
            end else begin
                e = q2.pop_front();
                chk("quotient2", {30'd0, i2.quotient}, {24'd0, e.q});
                chk("remainder2", {30'd0, i2.remainder}, {24'd0, e.r});
                chk("dbz2", {31'd0, i2.div_by_zero}, {31'd0, e.dbz});
            end
        end
    end

    task automatic wait_idle8();
        int n;
        n = 0;
        while ((i8.busy || i8.done) && n < 50) begin
            @(negedge clk); n++;
        end
        chk("idle8_timeout", {31'd0, i8.busy | i8.done}, 32'd0);
    endtask

    // One 8-bit operation; optionally pokes a start in the middle of CALC.
    task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input bit inject);
        int nb;
        int cyc;
        int d0;
        wait_idle8();
        @(negedge clk);
        i8.start = 1'b1; i8.a = aa; i8.b = bb;
        last8 = model(aa, bb, 8);
        q8.push_back(last8);
        d0 = done8_cnt;
        @(negedge clk);
        i8.start = 1'b0;
        i8.a = 8'($urandom); i8.b = 8'($urandom);
        nb = 0; cyc = 0;
        while (!i8.done && cyc < 40) begin
            if (i8.busy) nb++;
            if (inject && cyc == 2) begin
                i8.start = 1'b1; i8.a = 8'd9; i8.b = 8'd3;
            end else begin
                i8.start = 1'b0;
            end
            @(negedge clk); cyc++;
        end
        i8.start = 1'b0;
        chk("done_seen8", {31'd0, i8.done}, 32'd1);
        chk("busy_cycles8", nb, 32'd8);
        @(negedge clk);
        chk("done_pulse_len8", {31'd0, i8.done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("done_count8", done8_cnt - d0, 32'd1);
        chk("hold_q8", {24'd0, i8.quotient}, {24'd0, last8.q});
        chk("hold_r8", {24'd0, i8.remainder}, {24'd0, last8.r});
    endtask

    task automatic op2(input logic [1:0] aa, input logic [1:0] bb);
        int nb;
        int cyc;
        @(negedge clk);
        i2.start = 1'b1; i2.a = aa; i2.b = bb;
        q2.push_back(model(aa, bb, 2));
        @(negedge clk);
        i2.start = 1'b0;
        nb = 0; cyc = 0;
        while (!i2.done && cyc < 20) begin
            if (i2.busy) nb++;
            @(negedge clk); cyc++;
        end
        chk("done_seen2", {31'd0, i2.done}, 32'd1);
        chk("busy_cycles2", nb, 32'd2);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; done8_cnt = 0;
        rst_n = 1'b0;
        i8.start = 1'b0; i8.a = 8'd0; i8.b = 8'd0;
        i2.start = 1'b0; i2.a = 2'd0; i2.b = 2'd0;
        #3;
        chk("rst_q8", {24'd0, i8.quotient}, 32'd0);
        chk("rst_r8", {24'd0, i8.remainder}, 32'd0);
        chk("rst_flags8", {29'd0, i8.div_by_zero, i8.busy, i8.done}, 32'd0);
        chk("rst_flags2", {29'd0, i2.div_by_zero, i2.busy, i2.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op8(8'd200, 8'd7, 1'b0);
        op8(8'd255, 8'd1, 1'b0);
        op8(8'd5,   8'd9, 1'b0);
        op8(8'd100, 8'd0, 1'b0);
        op8(8'd10,  8'd3, 1'b0);
        op8(8'd200, 8'd7, 1'b1);

        // Reset in the 4th CALC cycle of 200/7 discards the operation.
        wait_idle8();
        @(negedge clk);
        i8.start = 1'b1; i8.a = 8'd200; i8.b = 8'd7;
        @(negedge clk);
        i8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_q8", {24'd0, i8.quotient}, 32'd0);
        chk("midrst_r8", {24'd0, i8.remainder}, 32'd0);
        chk("midrst_flags8", {29'd0, i8.div_by_zero, i8.busy, i8.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'd50, 8'd5, 1'b0);

        for (int k = 0; k < 30; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (k % 7 == 0) ? 8'd0 : 8'($urandom_range(255, 1));
            op8(ra, rb, 1'b0);
        end

        for (int ea = 0; ea < 4; ea++) begin
            for (int eb = 0; eb < 4; eb++) begin
                op2(2'(ea), 2'(eb));
            end
        end

        repeat (4) @(negedge clk);
        chk("sb8_drained", q8.size(), 32'd0);
        chk("sb2_drained", q2.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
